// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and constants for the pipeline sequencer.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_HALTED = 2'd3} state_t;
  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard between ID/EX load and IF/ID sources.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use
);
  assign load_use = idex_memread && (idex_rt != '0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: five-stage pipeline sequencer driving PC/latch enables, flush, bubble and drain-on-halt.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             debug_mode,
  input  logic             step_req,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             branch_taken,
  input  logic             halt_instr,
  output logic             pc_we,
  output logic             ifid_le,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic             halted,
  output logic [31:0]      cycle_count,
  output logic [15:0]      stall_count
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_drain_cnt, w_next_drain;
  logic            r_step_q;
  logic [31:0]     r_cycle_count;
  logic [15:0]     r_stall_count;
  logic            w_adv, w_load_use, w_stall_inc, w_cyc_inc;
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .idex_memread(idex_memread),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .load_use    (w_load_use)
  );
  // In debug mode only the rising edge of step_req lets the pipeline move.
  assign w_adv = debug_mode ? (step_req && !r_step_q) : 1'b1;
  always_comb begin
    w_next_state = r_state;
    w_next_drain = r_drain_cnt;
    pc_we        = 1'b0;
    ifid_le      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_en      = 1'b0;
    w_stall_inc  = 1'b0;
    w_cyc_inc    = 1'b0;
    case (r_state)
      ST_IDLE: w_next_state = start ? ST_RUN : ST_IDLE;
      ST_RUN: if (w_adv) begin
        w_cyc_inc = 1'b1;
        pipe_en   = 1'b1;
        if (w_load_use) begin
          idex_bubble = 1'b1;
          w_stall_inc = 1'b1;
        end else if (halt_instr) begin
          ifid_le      = 1'b1;
          ifid_flush   = 1'b1;
          w_next_drain = CW'(DRAIN_CYCLES - 1);
          w_next_state = ST_DRAIN;
        end else begin
          pc_we      = 1'b1;
          ifid_le    = 1'b1;
          ifid_flush = branch_taken;
        end
      end
      ST_DRAIN: if (w_adv) begin
        w_cyc_inc    = 1'b1;
        pipe_en      = 1'b1;
        ifid_le      = 1'b1;
        ifid_flush   = 1'b1;
        w_next_state = (r_drain_cnt == '0) ? ST_HALTED : ST_DRAIN;
        w_next_drain = (r_drain_cnt == '0) ? r_drain_cnt : r_drain_cnt - CW'(1);
      end
      default: w_next_state = ST_HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= '0;
      r_step_q      <= 1'b0;
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_next_state;
      r_drain_cnt   <= w_next_drain;
      r_step_q      <= step_req;
      r_cycle_count <= r_cycle_count + 32'(w_cyc_inc);
      if (w_stall_inc && r_stall_count != 16'hFFFF)
        r_stall_count <= r_stall_count + 16'd1;
    end
  end
  assign halted      = (r_state == ST_HALTED);
  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus random stimulus checked against a behavioural sequencer model.
module tb_pipeline_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 0, debug_mode = 0, step_req = 0, idex_memread = 0, branch_taken = 0, halt_instr = 0;
  logic [4:0]  idex_rt = 0, ifid_rs = 0, ifid_rt = 0;
  logic        pc_we, ifid_le, ifid_flush, idex_bubble, pipe_en, halted;
  logic [31:0] cycle_count;
  logic [15:0] stall_count;
  int errors = 0, checks = 0;
  bit  m_idle, m_active, m_halted, m_step_prev;
  int  m_drain_left, m_cyc, m_stall;
  pipeline_ctrl #(.DRAIN_CYCLES(3), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .debug_mode(debug_mode), .step_req(step_req),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .halt_instr(halt_instr), .pc_we(pc_we), .ifid_le(ifid_le),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_en(pipe_en), .halted(halted),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_idle = 1; m_active = 0; m_halted = 0; m_step_prev = 0;
    m_drain_left = 0; m_cyc = 0; m_stall = 0;
  endtask
  task automatic check_regs();
    chk("halted", 32'(halted), 32'(m_halted));
    chk("cycle_count", cycle_count, m_cyc);
    chk("stall_count", 32'(stall_count), m_stall);
  endtask
  // One clock: drive inputs, check enables against the model, clock, advance model, check registers.
  task automatic tick(input bit s, dbg, stp, mr, input logic [4:0] irt, rs, rt, input bit br, hl);
    bit adv, lu, e_pc, e_le, e_fl, e_bu, e_pe;
    start = s; debug_mode = dbg; step_req = stp; idex_memread = mr;
    idex_rt = irt; ifid_rs = rs; ifid_rt = rt; branch_taken = br; halt_instr = hl;
    #1;
    adv = dbg ? (stp && !m_step_prev) : 1'b1;
    lu  = mr && irt != 0 && (irt == rs || irt == rt);
    {e_pc, e_le, e_fl, e_bu, e_pe} = 5'b0;
    if (m_active && adv) begin
      e_pe = 1;
      if (m_drain_left > 0) {e_le, e_fl} = 2'b11;
      else if (lu) e_bu = 1;
      else if (hl) {e_le, e_fl} = 2'b11;
      else {e_pc, e_le, e_fl} = {2'b11, br};
    end
    chk("pc_we", 32'(pc_we), 32'(e_pc));
    chk("ifid_le", 32'(ifid_le), 32'(e_le));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bu));
    chk("pipe_en", 32'(pipe_en), 32'(e_pe));
    @(posedge clk);
    m_step_prev = stp;
    if (m_idle && s) begin
      m_idle = 0; m_active = 1;
    end else if (m_active && adv) begin
      m_cyc++;
      if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) begin m_active = 0; m_halted = 1; end
      end else if (lu) m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
      else if (hl) m_drain_left = 3;
    end
    #1;
    check_regs();
  endtask
  task automatic idle_tick(input bit s, dbg, stp);
    tick(s, dbg, stp, 0, 0, 0, 0, 0, 0);
  endtask
  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic pulse_reset();
    rst_n = 0;
    #1;
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_ifid_le", 32'(ifid_le), 0);
    chk("rst_pipe_en", 32'(pipe_en), 0);
    chk("rst_flush", 32'(ifid_flush), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_stalls", 32'(stall_count), 0);
    model_reset();
    #1 rst_n = 1;
  endtask
  initial begin
    model_reset();
    #2;
    pulse_reset();
    @(posedge clk); #1;
    // Start and ten free-running advances.
    idle_tick(1, 0, 0);
    for (int i = 0; i < 10; i++) idle_tick(0, 0, 0);
    chk("cycles_after_10", cycle_count, 32'd10);
    // Load-use hazards, zero register, hazard with branch, plain branch.
    tick(0, 0, 0, 1, 5, 5, 0, 0, 0);
    chk("stall_after_lu", 32'(stall_count), 32'd1);
    tick(0, 0, 0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 7, 3, 7, 1, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_tick(0, 0, 0);
    tick(0, 0, 0, 1, 9, 9, 9, 1, 1);
    // Halt, drain, then start must not leave HALTED.
    tick(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 4, 4, 4, 1, 1);
    chk("halted_after_drain", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) idle_tick(1, 0, 0);
    // Debug stepping: held step gives one advance, re-armed by a low cycle.
    pulse_reset();
    idle_tick(1, 1, 0);
    for (int i = 0; i < 5; i++) idle_tick(0, 1, 1);
    idle_tick(0, 1, 0);
    idle_tick(0, 1, 1);
    chk("debug_two_steps", cycle_count, 32'd2);
    // Halt in debug, toggle debug mid-drain, then reset mid-drain.
    idle_tick(0, 1, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 0, 1);
    idle_tick(0, 1, 1);
    idle_tick(0, 0, 1);
    pulse_reset();
    idle_tick(0, 0, 0);
    // Random rounds.
    for (int r = 0; r < 8; r++) begin
      pulse_reset();
      idle_tick(1, 0, 0);
      for (int i = 0; i < 150; i++)
        tick(0, ($urandom_range(3) == 0), $urandom_range(1), $urandom_range(1),
             5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
             ($urandom_range(3) == 0), ($urandom_range(40) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
